// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: refresh controller for a two-digit 7-segment display.
// Alternates digit A and digit B with an all-off gap between phases. Digit
// values are latched once per frame so a digit never changes mid-display.
module seg_scan_ctrl #(
  parameter int DIV            = 50000,
  parameter int BLANK          = 500,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] dig_a,
  input  logic [3:0] dig_b,
  input  logic       blank_a,
  input  logic       blank_b,
  output logic       sel,
  output logic [6:0] seg_a,
  output logic [6:0] seg_b,
  output logic       frame_tick
);

  localparam int MAX_N = (DIV > BLANK) ? DIV : BLANK;
  localparam int CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {
    SHOW_A = 2'd0,
    GAP_AB = 2'd1,
    SHOW_B = 2'd2,
    GAP_BA = 2'd3
  } state_t;

  // Hex digit to segment pattern, lit-by-1 form, bit0 = a ... bit6 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] p;
    p = 7'h00;
    case (v)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      4'hF: p = 7'h71;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  // Final pin pattern for one digit, honouring its blank flag and polarity.
  function automatic logic [6:0] drive_seg(input logic dark, input logic [3:0] v);
    if (dark)
      return SEG_OFF;
    else if (SEG_ACTIVE_LOW != 0)
      return ~hex_to_seg(v);
    else
      return hex_to_seg(v);
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       sh_dig_a_q, sh_dig_a_d;
  logic [3:0]       sh_dig_b_q, sh_dig_b_d;
  logic             sh_blank_a_q, sh_blank_a_d;
  logic             sh_blank_b_q, sh_blank_b_d;
  logic             sel_q, sel_d;
  logic [6:0]       seg_a_q, seg_a_d;
  logic [6:0]       seg_b_q, seg_b_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] cnt_last;
  logic             phase_end;

  // State, counter, frame shadows and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= GAP_BA;
      cnt_q        <= '0;
      sh_dig_a_q   <= 4'h0;
      sh_dig_b_q   <= 4'h0;
      sh_blank_a_q <= 1'b1;
      sh_blank_b_q <= 1'b1;
      sel_q        <= 1'b0;
      seg_a_q      <= SEG_OFF;
      seg_b_q      <= SEG_OFF;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh_dig_a_q   <= sh_dig_a_d;
      sh_dig_b_q   <= sh_dig_b_d;
      sh_blank_a_q <= sh_blank_a_d;
      sh_blank_b_q <= sh_blank_b_d;
      sel_q        <= sel_d;
      seg_a_q      <= seg_a_d;
      seg_b_q      <= seg_b_d;
      tick_q       <= tick_d;
    end
  end

  // Next state and next outputs; outputs are derived from the state being
  // entered so they line up with it in the same cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sh_dig_a_d   = sh_dig_a_q;
    sh_dig_b_d   = sh_dig_b_q;
    sh_blank_a_d = sh_blank_a_q;
    sh_blank_b_d = sh_blank_b_q;
    sel_d        = sel_q;
    seg_a_d      = SEG_OFF;
    seg_b_d      = SEG_OFF;
    tick_d       = 1'b0;
    cnt_last     = (state_q == SHOW_A || state_q == SHOW_B) ? DIV_LAST : BLANK_LAST;
    phase_end    = (cnt_q == cnt_last);

    if (en) begin
      if (phase_end) begin
        cnt_d = '0;
        case (state_q)
          SHOW_A:  state_d = GAP_AB;
          GAP_AB:  state_d = SHOW_B;
          SHOW_B:  state_d = GAP_BA;
          default: state_d = SHOW_A;
        endcase
        // Frame boundary: latch the digits so the whole frame is consistent.
        if (state_q == GAP_BA) begin
          sh_dig_a_d   = dig_a;
          sh_dig_b_d   = dig_b;
          sh_blank_a_d = blank_a;
          sh_blank_b_d = blank_b;
          tick_d       = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end

      case (state_d)
        SHOW_A: begin
          sel_d   = 1'b1;
          seg_a_d = drive_seg(sh_blank_a_d, sh_dig_a_d);
        end
        GAP_AB:  sel_d = 1'b1;
        SHOW_B: begin
          sel_d   = 1'b0;
          seg_b_d = drive_seg(sh_blank_b_d, sh_dig_b_d);
        end
        default: sel_d = 1'b0;
      endcase
    end
  end

  assign sel        = sel_q;
  assign seg_a      = seg_a_q;
  assign seg_b      = seg_b_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl: one instance per segment polarity sharing the
// same inputs, checked every cycle against a frame-position reference model.
module tb_seg_scan_ctrl;

  localparam int DIV   = 4;
  localparam int BLANK = 2;
  localparam int FRAME = 2 * (DIV + BLANK);

  localparam logic [6:0] TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] dig_a, dig_b;
  logic       blank_a, blank_b;
  logic       sel_lo, sel_hi, tick_lo, tick_hi;
  logic [6:0] seg_a_lo, seg_b_lo, seg_a_hi, seg_b_hi;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_tick = 0;
  int period = 0;
  bit rand_b = 1'b0;

  // Reference model: position within the frame (0 = first SHOW_A cycle),
  // latched digits, and the lit segments of each digit in lit-by-1 form.
  int         pos;
  logic [3:0] m_dig_a, m_dig_b;
  logic       m_bl_a, m_bl_b;
  logic       m_sel, m_tick;
  logic [6:0] m_lit_a, m_lit_b;

  seg_scan_ctrl #(.DIV(DIV), .BLANK(BLANK), .SEG_ACTIVE_LOW(1)) u_lo (
    .clk(clk), .rst(rst), .en(en), .dig_a(dig_a), .dig_b(dig_b),
    .blank_a(blank_a), .blank_b(blank_b), .sel(sel_lo), .seg_a(seg_a_lo),
    .seg_b(seg_b_lo), .frame_tick(tick_lo)
  );

  seg_scan_ctrl #(.DIV(DIV), .BLANK(BLANK), .SEG_ACTIVE_LOW(0)) u_hi (
    .clk(clk), .rst(rst), .en(en), .dig_a(dig_a), .dig_b(dig_b),
    .blank_a(blank_a), .blank_b(blank_b), .sel(sel_hi), .seg_a(seg_a_hi),
    .seg_b(seg_b_hi), .frame_tick(tick_hi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pos     = 2 * DIV + BLANK;
    m_dig_a = 4'h0;
    m_dig_b = 4'h0;
    m_bl_a  = 1'b1;
    m_bl_b  = 1'b1;
    m_sel   = 1'b0;
    m_tick  = 1'b0;
    m_lit_a = 7'h00;
    m_lit_b = 7'h00;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (en) begin
      pos    = (pos + 1) % FRAME;
      m_tick = (pos == 0);
      if (pos == 0) begin
        m_dig_a = dig_a;
        m_dig_b = dig_b;
        m_bl_a  = blank_a;
        m_bl_b  = blank_b;
      end
      m_sel   = (pos < DIV + BLANK);
      m_lit_a = (pos < DIV && !m_bl_a) ? TBL[m_dig_a] : 7'h00;
      m_lit_b = (pos >= DIV + BLANK && pos < 2 * DIV + BLANK && !m_bl_b) ?
                TBL[m_dig_b] : 7'h00;
    end else begin
      m_tick  = 1'b0;
      m_lit_a = 7'h00;
      m_lit_b = 7'h00;
    end
  endtask

  task automatic chk_all();
    chk("sel_lo",   {6'b0, sel_lo},  {6'b0, m_sel});
    chk("sel_hi",   {6'b0, sel_hi},  {6'b0, m_sel});
    chk("tick_lo",  {6'b0, tick_lo}, {6'b0, m_tick});
    chk("tick_hi",  {6'b0, tick_hi}, {6'b0, m_tick});
    chk("seg_a_lo", seg_a_lo, ~m_lit_a & 7'h7F);
    chk("seg_b_lo", seg_b_lo, ~m_lit_b & 7'h7F);
    chk("seg_a_hi", seg_a_hi, m_lit_a);
    chk("seg_b_hi", seg_b_hi, m_lit_b);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk_all();
    if (tick_lo) begin
      period    = cyc - last_tick;
      last_tick = cyc;
    end
    if (rand_b) begin
      dig_b   = 4'($urandom);
      blank_b = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic run_to_pos(input int target);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (pos == target) begin
        hit = 1'b1;
        break;
      end
    end
    chk_int("run_to_pos_reached", int'(hit), 1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; dig_a = 4'h3; dig_b = 4'hA; blank_a = 1'b0; blank_b = 1'b0;
    model_reset();
    step();
    step();
    chk("rst_seg_a", seg_a_lo, 7'h7F);
    rst = 1'b0;

    // Start-up: second edge after release enters SHOW_A with latched digits.
    step();
    step();
    chk("t1_first_tick", {6'b0, tick_lo}, 7'h01);
    chk("t1_seg_a", seg_a_lo, 7'h30);
    chk("t1_sel_a", {6'b0, sel_lo}, 7'h01);
    run_to_pos(DIV);
    chk("t1_gap_seg_a", seg_a_lo, 7'h7F);
    chk("t1_gap_seg_b", seg_b_lo, 7'h7F);
    run_to_pos(DIV + BLANK);
    chk("t1_seg_b", seg_b_lo, 7'h08);
    chk("t1_sel_b", {6'b0, sel_lo}, 7'h00);
    run_to_pos(0);
    chk_int("t1_period", period, FRAME);

    // Input change mid-frame waits for the next frame boundary.
    run_to_pos(DIV + BLANK);
    dig_a = 4'h8;
    run_to_pos(0);
    chk("t2_seg_a_8", seg_a_lo, 7'h00);

    // Latched blank flag darkens digit A only.
    blank_a = 1'b1;
    dig_a   = 4'h5;
    run_to_pos(0);
    chk("t3_blank_a", seg_a_lo, 7'h7F);
    run_to_pos(DIV - 1);
    chk("t3_blank_a_end", seg_a_lo, 7'h7F);
    run_to_pos(DIV + BLANK);
    chk("t3_seg_b", seg_b_lo, 7'h08);

    // Stall in SHOW_B count 1.
    run_to_pos(DIV + BLANK + 1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_stall_seg_a", seg_a_lo, 7'h7F);
      chk("t4_stall_seg_b", seg_b_lo, 7'h7F);
      chk("t4_stall_sel", {6'b0, sel_lo}, 7'h00);
    end
    en = 1'b1;
    step();
    chk("t4_resume_seg_b", seg_b_lo, 7'h08);
    run_to_pos(0);
    chk_int("t4_period", period, FRAME + 5);

    // Asynchronous reset in the middle of SHOW_A.
    blank_a = 1'b0;
    run_to_pos(1);
    dig_a = 4'hC;
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_seg_a_lo", seg_a_lo, 7'h7F);
    chk("t5_async_seg_a_hi", seg_a_hi, 7'h00);
    chk("t5_async_sel", {6'b0, sel_lo}, 7'h00);
    model_reset();
    chk_all();
    step();
    rst = 1'b0;
    step();
    step();
    chk("t5_relatch_tick", {6'b0, tick_lo}, 7'h01);
    chk("t5_relatch_seg_a", seg_a_lo, 7'h46);

    // Sweep every hex value through digit A with random digit B traffic.
    rand_b = 1'b1;
    for (int v = 0; v < 16; v++) begin
      dig_a = 4'(v);
      run_to_pos(0);
      chk("t6_sweep_lo", seg_a_lo, ~TBL[v] & 7'h7F);
      chk("t6_sweep_hi", seg_a_hi, TBL[v]);
    end

    // Fully random traffic including enable gaps.
    for (int i = 0; i < 300; i++) begin
      en      = ($urandom_range(0, 4) != 0);
      dig_a   = 4'($urandom);
      blank_a = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
